booth_ctrl: RTL and testbench
=============================

Name: booth_ctrl

Overview:
- Control unit that sequences the 6-bit radix-2 Booth multiplier datapath: X (multiplier), Y (multiplicand), A (accumulator), E (Booth extra bit) and the add/sub ALU.
- Loads both operands from the shared inbus, runs N add/sub + arithmetic-shift iterations, then uploads the product over the datapath's out bus, high word (A) first, low word (X) second.
- Sits between the top-level start/result handshake and the datapath control pins; it has no data path of its own.

Parameters:
- N, 6, operand width; also the iteration count.
- CNT_W, 3, iteration counter width; must satisfy 2^CNT_W >= N.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request a multiplication; sampled only in IDLE
- decision_bits  in  2  {X[0], E} from the datapath
- ldX, shX, clrX  out  1 each  X register controls
- ldY  out  1  Y load
- ldA, shA, clrA  out  1 each  A register controls
- lde, clre  out  1 each  E register controls
- add, sub  out  1 each  ALU operation select
- upload_selector  out  2  01 = out shows X, 10 = out shows A, 00 = idle
- ready  out  1  high only in IDLE
- out_valid  out  1  datapath out carries a product word
- done  out  1  single-cycle pulse on the last upload cycle

Behaviour:
- FSM states: IDLE, LOAD_X, LOAD_Y, ARITH, SHIFT, UP_HI, UP_LO.
- Default: every control output is 0 unless listed for the current state. Outputs are Moore, except add/sub/ldA in ARITH, which decode decision_bits combinationally.
- IDLE: ready=1. start=1 -> LOAD_X; otherwise stay.
- LOAD_X: ldX=1, clrA=1, clre=1. inbus must carry the multiplier this cycle. Iteration counter cleared to 0. Next state LOAD_Y.
- LOAD_Y: ldY=1. inbus must carry the multiplicand. Next state ARITH.
- ARITH, decoded from decision_bits:
  - 10: sub=1, ldA=1 (A <= A - Y).
  - 01: add=1, ldA=1 (A <= A + Y).
  - 00 or 11: no control asserted.
  - add and sub are never high together. Next state SHIFT.
- SHIFT: shA=1, shX=1, lde=1 in the same cycle. A shifts arithmetically, X takes old A[0] at its MSB, and E takes old X[0].
  - If counter == N-1: counter <= 0, next UP_HI.
  - Otherwise: counter <= counter + 1, next ARITH.
- UP_HI: upload_selector=10, out_valid=1. Next state UP_LO.
- UP_LO: upload_selector=01, out_valid=1, done=1. Next state IDLE.
- Latency: start sampled at edge k -> done high in cycle k + 2 + 2N + 2, which is 16 cycles later for N=6. Next start is accepted in the following cycle (IDLE).
- Product format: {A, X}, 2N-bit two's complement.
- start while not in IDLE is ignored; it is neither queued nor does it restart the operation.
- Reset: rst=1 at any clock edge, including mid-operation, forces IDLE and counter 0. All outputs become 0 except ready=1 and upload_selector=00. The datapath is not cleared by this block; the next LOAD_X reinitialises A and E.
- Mutual exclusion:
  - ldX and shX are never high together.
  - ldA and shA are never high together.
  - clrA is only asserted without ldA/shA.
  - upload_selector is nonzero only in UP_HI/UP_LO.

Test Plan:
1. rst high for 2 cycles, then low -> ready=1, all other outputs 0, upload_selector=00. No state change while start=0.
2. start with X=000011, then Y=000101 (3 × 5):
   - First ARITH sees decision 10 and asserts sub.
   - done 16 cycles after start.
   - UP_HI word A=000000, UP_LO word X=001111 (15).
3. X=111101, Y=000101 (-3 × 5) -> product 111111_110001 (-15): A=111111, X=110001.
4. X=100000, Y=100000 (-32 × -32) -> product 010000_000000 (1024). Check that every ARITH cycle with decision 00 or 11 has add=sub=ldA=0.
5. Pulse start again during the SHIFT of iteration 3 -> ignored; exactly one done pulse. Then assert rst during ARITH of a new operation -> next cycle IDLE, ready=1, no done. A fresh 3 × 5 run then still yields 15.
6. Back-to-back operations, with start held high through done -> second operation begins from the IDLE cycle after UP_LO. Both products are correct; ready is low for exactly 16 cycles per operation.

Source files
------------

// File: rtl/booth_ctrl.sv
// booth_ctrl: sequencer for a radix-2 Booth multiplier datapath.
// Loads X then Y from the shared inbus, runs N add/sub + shift iterations,
// then presents the product on the datapath out bus, A (high word) first.
module booth_ctrl #(
    parameter int unsigned N     = 6,
    parameter int unsigned CNT_W = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] decision_bits,
    output logic       ldX,
    output logic       shX,
    output logic       clrX,
    output logic       ldY,
    output logic       ldA,
    output logic       shA,
    output logic       clrA,
    output logic       lde,
    output logic       clre,
    output logic       add,
    output logic       sub,
    output logic [1:0] upload_selector,
    output logic       ready,
    output logic       out_valid,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_X,
        LOAD_Y,
        ARITH,
        SHIFT,
        UP_HI,
        UP_LO
    } state_t;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    // State and iteration counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state, counter update and control decode; every output defaults low.
    always_comb begin
        state_next      = state;
        cnt_next        = cnt;
        ldX             = 1'b0;
        shX             = 1'b0;
        clrX            = 1'b0;
        ldY             = 1'b0;
        ldA             = 1'b0;
        shA             = 1'b0;
        clrA            = 1'b0;
        lde             = 1'b0;
        clre            = 1'b0;
        add             = 1'b0;
        sub             = 1'b0;
        upload_selector = 2'b00;
        ready           = 1'b0;
        out_valid       = 1'b0;
        done            = 1'b0;

        unique case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_next = LOAD_X;
                end
            end
            LOAD_X: begin
                ldX        = 1'b1;
                clrA       = 1'b1;
                clre       = 1'b1;
                cnt_next   = '0;
                state_next = LOAD_Y;
            end
            LOAD_Y: begin
                ldY        = 1'b1;
                state_next = ARITH;
            end
            ARITH: begin
                // {X[0], E}: 10 starts a run of ones (subtract), 01 ends one (add).
                unique case (decision_bits)
                    2'b10: begin
                        sub = 1'b1;
                        ldA = 1'b1;
                    end
                    2'b01: begin
                        add = 1'b1;
                        ldA = 1'b1;
                    end
                    default: ;
                endcase
                state_next = SHIFT;
            end
            SHIFT: begin
                shA = 1'b1;
                shX = 1'b1;
                lde = 1'b1;
                if (cnt == LAST_ITER) begin
                    cnt_next   = '0;
                    state_next = UP_HI;
                end else begin
                    cnt_next   = cnt + 1'b1;
                    state_next = ARITH;
                end
            end
            UP_HI: begin
                upload_selector = 2'b10;
                out_valid       = 1'b1;
                state_next      = UP_LO;
            end
            UP_LO: begin
                upload_selector = 2'b01;
                out_valid       = 1'b1;
                done            = 1'b1;
                state_next      = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_booth_ctrl.sv
// tb_booth_ctrl: directed bench for booth_ctrl driving a small behavioural
// Booth datapath (X, Y, A, E) so that products can be checked end to end.
module tb_booth_ctrl;

    localparam int unsigned N = 6;

    logic       clk;
    logic       rst;
    logic       start;
    logic [1:0] decision_bits;
    logic       ldX, shX, clrX, ldY, ldA, shA, clrA, lde, clre, add, sub;
    logic [1:0] upload_selector;
    logic       ready, out_valid, done;

    booth_ctrl #(.N(N), .CNT_W(3)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .decision_bits   (decision_bits),
        .ldX             (ldX),
        .shX             (shX),
        .clrX            (clrX),
        .ldY             (ldY),
        .ldA             (ldA),
        .shA             (shA),
        .clrA            (clrA),
        .lde             (lde),
        .clre            (clre),
        .add             (add),
        .sub             (sub),
        .upload_selector (upload_selector),
        .ready           (ready),
        .out_valid       (out_valid),
        .done            (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural datapath. A carries one guard bit so that A - Y cannot
    // overflow when Y is the most negative operand; the out bus shows A[N-1:0].
    logic [N-1:0] x_op, y_op;
    logic [N:0]   a_reg;
    logic [N-1:0] x_reg, y_reg;
    logic         e_reg;

    assign decision_bits = {x_reg[0], e_reg};

    // Datapath registers follow the controller's load/shift/clear pins.
    always @(posedge clk) begin
        if (clrA) a_reg <= '0;
        if (clre) e_reg <= 1'b0;
        if (ldX)  x_reg <= x_op;
        if (ldY)  y_reg <= y_op;
        if (ldA) begin
            if (add)      a_reg <= a_reg + {y_reg[N-1], y_reg};
            else if (sub) a_reg <= a_reg - {y_reg[N-1], y_reg};
        end
        if (shA) a_reg <= {a_reg[N], a_reg[N:1]};
        if (shX) x_reg <= {a_reg[0], x_reg[N-1:1]};
        if (lde) e_reg <= x_reg[0];
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor state, updated once per cycle from step().
    int           cyc = 0;
    int           done_cnt = 0;
    int           viol = 0;
    int           low_run = 0;
    int           run_q[$];
    logic [N-1:0] hi_word, lo_word;

    task automatic step();
        @(negedge clk);
        cyc++;
        if (!rst) begin
            if (out_valid && upload_selector == 2'b10) hi_word = a_reg[N-1:0];
            if (out_valid && upload_selector == 2'b01) lo_word = x_reg;
            if (done) done_cnt++;
            if ((ldX && shX) || (ldA && shA) || (clrA && (ldA || shA)) || (add && sub) ||
                (upload_selector == 2'b11) || (out_valid != (upload_selector != 2'b00)) ||
                (done && upload_selector != 2'b01) || clrX)
                viol++;
        end
        if (!ready) low_run++;
        else begin
            if (low_run != 0) run_q.push_back(low_run);
            low_run = 0;
        end
    endtask

    // One multiplication. glitch_at pulses start in that cycle; abort_at
    // asserts rst in that cycle and expects a clean return to IDLE.
    task automatic run_op(input string tag, input logic [N-1:0] xv, input logic [N-1:0] yv,
                          input logic [N-1:0] exp_hi, input logic [N-1:0] exp_lo,
                          input int glitch_at, input int abort_at,
                          output logic [4:0] first_arith);
        int n;
        int d0;
        int v0;
        int ctrl_err;
        bit got_done;
        ctrl_err    = 0;
        got_done    = 0;
        first_arith = '0;
        x_op  = xv;
        y_op  = yv;
        d0    = done_cnt;
        v0    = viol;
        start = 1'b1;
        step();
        start = 1'b0;
        n = 1;
        while (n < 40) begin
            if (n >= 3 && n <= 14) begin
                if (n % 2 == 1) begin
                    if (n == 3) first_arith = {decision_bits, add, sub, ldA};
                    if ({add, sub, ldA} !== {decision_bits == 2'b01, decision_bits == 2'b10,
                                             decision_bits == 2'b01 || decision_bits == 2'b10})
                        ctrl_err++;
                end else if ({shA, shX, lde} !== 3'b111) begin
                    ctrl_err++;
                end
            end
            if (n == abort_at) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                check({tag, "_abort_ready"}, 32'(ready), 32'd1);
                check({tag, "_abort_outs"}, 32'({out_valid, done, upload_selector, ldA, sub, add}), 32'd0);
                break;
            end
            if (done) begin
                got_done = 1;
                break;
            end
            start = (n + 1 == glitch_at);
            step();
            start = 1'b0;
            n++;
        end
        if (abort_at == 0) begin
            check({tag, "_latency"}, 32'(n), 32'd16);
            check({tag, "_hi"}, 32'(hi_word), 32'(exp_hi));
            check({tag, "_lo"}, 32'(lo_word), 32'(exp_lo));
            check({tag, "_ctrl"}, 32'(ctrl_err), 32'd0);
        end
        check({tag, "_mutex"}, 32'(viol - v0), 32'd0);
        check({tag, "_done_seen"}, 32'(got_done), (abort_at == 0) ? 32'd1 : 32'd0);
    endtask

    logic [4:0] fa;
    int         d_before;
    int         t_done1;
    int         t_done2;
    logic [N-1:0] hi1, lo1;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        x_op  = '0;
        y_op  = '0;

        // 1: reset, then idle with start low.
        step();
        step();
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_outs", 32'({ldX, shX, clrX, ldY, ldA, shA, clrA, lde, clre, add, sub,
                               upload_selector, out_valid, done}), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("idle_ready", 32'(ready), 32'd1);
        check("idle_outs", 32'({ldX, shX, clrX, ldY, ldA, shA, clrA, lde, clre, add, sub,
                                upload_selector, out_valid, done}), 32'd0);

        // 2: 3 x 5 = 15; first ARITH decision 10 -> sub, ldA.
        run_op("p3x5", 6'b000011, 6'b000101, 6'b000000, 6'b001111, 0, 0, fa);
        check("p3x5_first_arith", 32'(fa), 32'(5'b10_011));
        step();

        // 3: -3 x 5 = -15.
        run_op("m3x5", 6'b111101, 6'b000101, 6'b111111, 6'b110001, 0, 0, fa);
        step();

        // 4: -32 x -32 = 1024; mostly 00 decisions.
        run_op("m32sq", 6'b100000, 6'b100000, 6'b010000, 6'b000000, 0, 0, fa);
        step();

        // 5a: start pulse in the third SHIFT is ignored.
        d_before = done_cnt;
        run_op("glitch", 6'b000111, 6'b000011, 6'b000000, 6'b010101, 8, 0, fa);
        for (int i = 0; i < 24; i++) step();
        check("glitch_one_done", 32'(done_cnt - d_before), 32'd1);
        check("glitch_idle", 32'(ready), 32'd1);

        // 5b: reset during ARITH aborts cleanly.
        d_before = done_cnt;
        run_op("abort", 6'b000011, 6'b000101, '0, '0, 0, 5, fa);
        for (int i = 0; i < 24; i++) step();
        check("abort_no_done", 32'(done_cnt - d_before), 32'd0);
        check("abort_idle", 32'(ready), 32'd1);
        run_op("after_abort", 6'b000011, 6'b000101, 6'b000000, 6'b001111, 0, 0, fa);
        step();

        // 6: back-to-back with start held high through both operations.
        run_q.delete();
        d_before = done_cnt;
        t_done1  = 0;
        t_done2  = 0;
        hi1      = '0;
        lo1      = '0;
        x_op     = 6'b000011;
        y_op     = 6'b000101;
        start    = 1'b1;
        for (int i = 0; i < 60; i++) begin
            step();
            if (done && done_cnt - d_before == 1) begin
                t_done1 = cyc;
                hi1     = hi_word;
                lo1     = lo_word;
                x_op    = 6'b111101;
            end
            if (done && done_cnt - d_before == 2) begin
                t_done2 = cyc;
                start   = 1'b0;
                break;
            end
        end
        start = 1'b0;
        step();
        step();
        check("b2b_hi1", 32'(hi1), 32'(6'b000000));
        check("b2b_lo1", 32'(lo1), 32'(6'b001111));
        check("b2b_hi2", 32'(hi_word), 32'(6'b111111));
        check("b2b_lo2", 32'(lo_word), 32'(6'b110001));
        check("b2b_gap", 32'(t_done2 - t_done1), 32'd17);
        check("b2b_runs", 32'(run_q.size()), 32'd2);
        if (run_q.size() == 2) begin
            check("b2b_low1", 32'(run_q[0]), 32'd16);
            check("b2b_low2", 32'(run_q[1]), 32'd16);
        end
        check("b2b_mutex", 32'(viol), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
